// File: rtl/riscv_ahb_ram_ctrl.sv
// AHB-Lite slave front-end for a single-port (1RW) synchronous RAM.
// Inserts one wait state on read-after-write and gives a two-cycle ERROR for illegal transfers.
module riscv_ahb_ram_ctrl #(
  parameter int unsigned ABITS = 10,
  parameter int unsigned DBITS = 32
) (
  input  logic             rst_ni,
  input  logic             clk_i,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HBURST,
  input  logic [3:0]       HPROT,
  input  logic [DBITS-1:0] HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [DBITS-1:0] HRDATA,
  output logic [ABITS-1:0] ram_addr_o,
  output logic             ram_we_o,
  output logic [3:0]       ram_be_o,
  output logic [DBITS-1:0] ram_din_o,
  input  logic [DBITS-1:0] ram_dout_i
);

  localparam int unsigned BE_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_STALL,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t           state_q, state_d;
  logic [ABITS-1:0] addr_q;
  logic [BE_W-1:0]  be_q;
  logic [ABITS-1:0] addr_hold_q;
  logic [ABITS-1:0] ram_addr_c;
  logic [ABITS-1:0] haddr_word_c;
  logic [BE_W-1:0]  be_c;
  logic             illegal_c;
  logic             accept_c;
  logic             unused_bits;

  assign unused_bits  = ^{HBURST, HPROT, HTRANS[0], HADDR[31:ABITS+2]};
  assign haddr_word_c = HADDR[ABITS+1:2];

  // Transfers can only be taken in states that signal HREADYOUT=1.
  assign accept_c = HSEL & HREADY & HTRANS[1] &
                    ((state_q == S_IDLE) | (state_q == S_WR) |
                     (state_q == S_RD)   | (state_q == S_ERR2));

  // Size/alignment legality and byte-lane decode.
  always_comb begin
    illegal_c = 1'b0;
    be_c      = 4'b1111;
    unique case (HSIZE)
      3'd0: be_c = BE_W'(4'b0001 << HADDR[1:0]);
      3'd1: begin
        be_c      = HADDR[1] ? 4'b1100 : 4'b0011;
        illegal_c = HADDR[0];
      end
      3'd2: illegal_c = (HADDR[1:0] != 2'b00);
      default: illegal_c = 1'b1;
    endcase
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    HRDATA     = '0;
    ram_we_o   = 1'b0;
    ram_be_o   = '0;
    ram_din_o  = '0;
    ram_addr_c = addr_hold_q;

    unique case (state_q)
      S_WR: begin
        ram_we_o   = 1'b1;
        ram_be_o   = be_q;
        ram_din_o  = HWDATA;
        ram_addr_c = addr_q;
      end
      S_RD:       HRDATA = ram_dout_i;
      S_RD_STALL: begin
        HREADYOUT  = 1'b0;
        ram_addr_c = addr_q;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2:  HRESP = 1'b1;
      default: ;
    endcase

    unique case (state_q)
      S_RD_STALL: state_d = S_RD;
      S_ERR1:     state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept_c) begin
          if (illegal_c) begin
            state_d = S_ERR1;
          end else if (HWRITE) begin
            state_d = S_WR;
          end else if (state_q == S_WR) begin
            // Port busy with the write: re-present the read address next cycle.
            state_d = S_RD_STALL;
          end else begin
            state_d    = S_RD;
            ram_addr_c = haddr_word_c;
          end
        end
      end
    endcase
  end

  assign ram_addr_o = ram_addr_c;

  // State register and latched address-phase control.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      be_q        <= '0;
      addr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_hold_q <= ram_addr_c;
      if (accept_c) begin
        addr_q <= haddr_word_c;
        be_q   <= be_c;
      end
    end
  end

endmodule

// File: tb/tb_riscv_ahb_ram_ctrl.sv
// Bench for riscv_ahb_ram_ctrl: pipelined AHB master, 1RW RAM model and reference memory
// feeding a scoreboard of expected responses.
`timescale 1ns/1ps
module tb_riscv_ahb_ram_ctrl;

  localparam int unsigned ABITS = 10;
  localparam int unsigned DEPTH = 1 << ABITS;

  logic              clk_i  = 1'b0;
  logic              rst_ni = 1'b0;
  logic              HSEL   = 1'b0;
  logic [31:0]       HADDR  = '0;
  logic              HWRITE = 1'b0;
  logic [2:0]        HSIZE  = '0;
  logic [1:0]        HTRANS = '0;
  logic [2:0]        HBURST = '0;
  logic [3:0]        HPROT  = 4'b0011;
  logic [31:0]       HWDATA = '0;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;
  logic [ABITS-1:0]  ram_addr_o;
  logic              ram_we_o;
  logic [3:0]        ram_be_o;
  logic [31:0]       ram_din_o;
  logic [31:0]       ram_dout_i;

  always #5 clk_i = ~clk_i;
  assign HREADY = HREADYOUT;

  riscv_ahb_ram_ctrl #(.ABITS(ABITS), .DBITS(32)) dut (
    .rst_ni     (rst_ni),
    .clk_i      (clk_i),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HTRANS     (HTRANS),
    .HBURST     (HBURST),
    .HPROT      (HPROT),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .ram_addr_o (ram_addr_o),
    .ram_we_o   (ram_we_o),
    .ram_be_o   (ram_be_o),
    .ram_din_o  (ram_din_o),
    .ram_dout_i (ram_dout_i)
  );

  function automatic logic [31:0] init_val(input int i);
    return (32'h0101_0101 * 32'(i + 1)) ^ 32'h5A3C_C35A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Synchronous 1RW RAM with byte enables; read data valid the cycle after the address.
  logic [31:0] mem [DEPTH];
  logic        mem_init = 1'b1;
  always @(posedge clk_i) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (ram_we_o) begin
      mem[ram_addr_o] <= merge(mem[ram_addr_o], ram_din_o, ram_be_o);
    end
    ram_dout_i <= mem[ram_addr_o];
  end

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    logic             rd;
    logic             err;
    logic             wr_ok;
    logic [31:0]      data;
    int               waits;
    logic [ABITS-1:0] waddr;
    logic [3:0]       be;
  } sb_t;

  xfer_t       seq[$];
  sb_t         sb_q[$];
  logic [31:0] ref_mem [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [31:0] a, input logic [2:0] s);
    if (s == 3'd0) return 1'b1;
    if (s == 3'd1) return (a[0] == 1'b0);
    if (s == 3'd2) return (a[1:0] == 2'b00);
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [2:0] s);
    logic [3:0] r;
    r = 4'b1111;
    if (s == 3'd0) begin
      r = 4'b0000;
      r[a[1:0]] = 1'b1;
    end else if (s == 3'd1) begin
      r = a[1] ? 4'b1100 : 4'b0011;
    end
    return r;
  endfunction

  task automatic add(input logic sel, input logic [1:0] trans, input logic wr,
                     input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
    seq.push_back(x);
  endtask

  task automatic add_wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    add(1'b1, 2'b10, 1'b1, a, s, d);
  endtask
  task automatic add_rd(input logic [31:0] a, input logic [2:0] s);
    add(1'b1, 2'b10, 1'b0, a, s, 32'h0);
  endtask
  task automatic add_idle();
    add(1'b1, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
  endtask

  // Pipelined master: address phase of one transfer overlaps the data phase of the previous.
  task automatic run_seq();
    int          idx = 0;
    int          guard = 0;
    int          waits = 0;
    logic        ap_act = 1'b0;
    logic        dp_act = 1'b0;
    logic        prev_wr = 1'b0;
    logic        first = 1'b0;
    logic        rdy = 1'b1;
    logic [31:0] ap_wdata = '0;
    logic [ABITS-1:0] wa;
    xfer_t       x;
    sb_t         e;
    while ((idx < seq.size() || ap_act || dp_act) && guard < 5000) begin
      guard++;
      @(posedge clk_i); #1;
      if (rdy) begin
        dp_act = ap_act;
        first  = 1'b1;
        waits  = 0;
        HWDATA = ap_wdata;
        ap_act = 1'b0;
        if (idx < seq.size()) begin
          x = seq[idx];
          idx++;
          HSEL = x.sel; HTRANS = x.trans; HWRITE = x.wr; HADDR = x.addr; HSIZE = x.size;
          if (x.sel && x.trans[1]) begin
            wa      = x.addr[ABITS+1:2];
            e.err   = !is_legal(x.addr, x.size);
            e.rd    = !x.wr;
            e.wr_ok = x.wr && !e.err;
            e.waddr = wa;
            e.be    = exp_be(x.addr, x.size);
            e.waits = (e.err || (e.rd && prev_wr)) ? 1 : 0;
            e.data  = x.wr ? x.wdata : ref_mem[wa];
            if (e.wr_ok) ref_mem[wa] = merge(ref_mem[wa], x.wdata, e.be);
            sb_q.push_back(e);
            ap_act   = 1'b1;
            ap_wdata = x.wdata;
            prev_wr  = e.wr_ok;
          end else begin
            prev_wr = 1'b0;
          end
        end else begin
          HTRANS = 2'b00;
          HWRITE = 1'b0;
        end
      end
      @(negedge clk_i);
      if (dp_act && sb_q.size() > 0) begin
        e = sb_q[0];
        if (first && e.wr_ok) begin
          check("wr_we",   32'(ram_we_o),   32'd1);
          check("wr_addr", 32'(ram_addr_o), 32'(e.waddr));
          check("wr_be",   32'(ram_be_o),   32'(e.be));
          check("wr_din",  ram_din_o,       e.data);
        end else if (!e.wr_ok) begin
          check("no_we", 32'(ram_we_o), 32'd0);
          check("no_be", 32'(ram_be_o), 32'd0);
        end
        if (!HREADYOUT) begin
          waits++;
          check("wait_resp",  32'(HRESP), 32'(e.err));
          check("wait_rdata", HRDATA,     32'h0);
        end else begin
          check("resp",  32'(HRESP), 32'(e.err));
          check("rdata", HRDATA, (e.rd && !e.err) ? e.data : 32'h0);
          check("waits", 32'(waits), 32'(e.waits));
          void'(sb_q.pop_front());
        end
        first = 1'b0;
      end else begin
        check("idle_ready", 32'(HREADYOUT), 32'd1);
        check("idle_resp",  32'(HRESP),     32'd0);
        check("idle_we",    32'(ram_we_o),  32'd0);
        check("idle_rdata", HRDATA,         32'h0);
      end
      rdy = HREADYOUT;
    end
    check("seq_drained", 32'(sb_q.size()), 32'd0);
    seq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    repeat (3) @(posedge clk_i);
    mem_init = 1'b0;
    @(negedge clk_i);
    check("rst_ready", 32'(HREADYOUT),  32'd1);
    check("rst_resp",  32'(HRESP),      32'd0);
    check("rst_we",    32'(ram_we_o),   32'd0);
    check("rst_be",    32'(ram_be_o),   32'd0);
    check("rst_addr",  32'(ram_addr_o), 32'd0);
    check("rst_rdata", HRDATA,          32'h0);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    // Word write then read; read-after-write stall; byte write merge.
    add_wr(32'h10, 3'd2, 32'hDEAD_BEEF); add_idle(); add_rd(32'h10, 3'd2);
    add_wr(32'h20, 3'd2, 32'h1234_5678); add_rd(32'h20, 3'd2);
    add_wr(32'h13, 3'd0, 32'hAB00_0000); add_idle(); add_rd(32'h10, 3'd2);
    // Illegal size write leaves memory intact; misaligned halfword read errors.
    add_wr(32'h00, 3'd3, 32'h5555_5555); add_idle(); add_rd(32'h00, 3'd2);
    add_rd(32'h01, 3'd1);
    // Back-to-back halfword/byte writes, then read-after-read.
    add_wr(32'h30, 3'd1, 32'h0000_BEEF); add_wr(32'h32, 3'd1, 32'hCAFE_0000);
    add_wr(32'h34, 3'd0, 32'h0000_0011); add_wr(32'h35, 3'd0, 32'h0000_2200);
    add_rd(32'h30, 3'd2); add_rd(32'h34, 3'd2);
    // BUSY and an unselected write are ignored.
    add(1'b1, 2'b01, 1'b1, 32'h30, 3'd2, 32'hFFFF_FFFF);
    add(1'b0, 2'b10, 1'b1, 32'h30, 3'd2, 32'hFFFF_FFFF);
    add_rd(32'h30, 3'd2);
    // Upper address bits wrap.
    add_wr(32'h1008, 3'd2, 32'h0BAD_F00D); add_rd(32'h08, 3'd2);
    // More illegal forms, back to back.
    add_rd(32'h22, 3'd2); add_wr(32'h33, 3'd1, 32'h7777_7777); add_rd(32'h30, 3'd4);
    add_rd(32'h30, 3'd2);
    // Write after read, then read back.
    add_rd(32'h08, 3'd2); add_wr(32'h08, 3'd2, 32'h1111_2222); add_rd(32'h08, 3'd2);
    add_rd(32'h1C, 3'd1); add_rd(32'h1E, 3'd0);
    run_seq();

    // Asynchronous reset during a write data phase drops the write.
    @(posedge clk_i); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h40; HSIZE = 3'd2;
    @(posedge clk_i); #1;
    HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hFFFF_0000;
    #1 check("pre_rst_we", 32'(ram_we_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("arst_we",    32'(ram_we_o),  32'd0);
    check("arst_ready", 32'(HREADYOUT), 32'd1);
    check("arst_resp",  32'(HRESP),     32'd0);
    check("arst_be",    32'(ram_be_o),  32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    add_rd(32'h40, 3'd2);
    run_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
